// File: rtl/eth_tx_axis_arbiter_if.sv
// AXI-stream bundle between the requesters, the frame arbiter and the MAC tx_axis input.
// The slave modport is the arbiter's view; the master modport is the requester/MAC side.
interface eth_tx_axis_arbiter_if #(
  parameter int PORTS      = 2,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 8
);
  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [PORTS-1:0]            s_axis_tvalid;
  logic [PORTS-1:0]            s_axis_tready;
  logic [PORTS-1:0]            s_axis_tlast;
  logic [PORTS-1:0]            s_axis_tuser;
  logic [DATA_WIDTH-1:0]       m_axis_tdata;
  logic [KEEP_WIDTH-1:0]       m_axis_tkeep;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
  logic                        m_axis_tlast;
  logic                        m_axis_tuser;

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/eth_tx_axis_arbiter.sv
// Frame-granular round-robin arbiter feeding the MAC TX frame FIFO, with a
// single output register stage and oversize-frame truncation.
module eth_tx_axis_arbiter #(
  parameter  int PORTS      = 2,
  parameter  int DATA_WIDTH = 64,
  parameter  int KEEP_WIDTH = 8,
  parameter  int MAX_BEATS  = 1200,
  localparam int IDX_W      = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                 logic_clk,
  input  logic                 logic_rst,
  eth_tx_axis_arbiter_if.slave axis,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_index,
  output logic                 frame_done,
  output logic                 frame_truncated
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mData_q, mData_d;
  logic [KEEP_WIDTH-1:0] mKeep_q, mKeep_d;
  logic                  mValid_q, mValid_d;
  logic                  mLast_q, mLast_d;
  logic                  mUser_q, mUser_d;

  logic [DATA_WIDTH-1:0] selData;
  logic [KEEP_WIDTH-1:0] selKeep;
  logic                  selValid, selLast, selUser;
  logic [PORTS-1:0]      selOneHot;
  logic [PORTS-1:0]      sReady;
  logic                  loadEn;
  logic                  found;

  assign loadEn = !mValid_q || axis.m_axis_tready;

  // Mux out the beat of the port currently holding the grant.
  always_comb begin
    selData   = '0;
    selKeep   = '0;
    selValid  = 1'b0;
    selLast   = 1'b0;
    selUser   = 1'b0;
    selOneHot = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (grant_q == IDX_W'(p)) begin
        selOneHot[p] = 1'b1;
        selData      = axis.s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        selKeep      = axis.s_axis_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
        selValid     = axis.s_axis_tvalid[p];
        selLast      = axis.s_axis_tlast[p];
        selUser      = axis.s_axis_tuser[p];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_d          = last_q;
    cnt_d           = cnt_q;
    mData_d         = mData_q;
    mKeep_d         = mKeep_q;
    mLast_d         = mLast_q;
    mUser_d         = mUser_q;
    mValid_d        = mValid_q && !axis.m_axis_tready;
    sReady          = '0;
    frame_done      = 1'b0;
    frame_truncated = 1'b0;
    found           = 1'b0;

    case (state_q)
      IDLE: begin
        // Search starts one past the previous winner so every port gets a turn.
        for (int off = 1; off <= PORTS; off++) begin
          for (int p = 0; p < PORTS; p++) begin
            if (!found && axis.s_axis_tvalid[p] && (p == (int'(last_q) + off) % PORTS)) begin
              found   = 1'b1;
              grant_d = IDX_W'(p);
            end
          end
        end
        if (found) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
      end

      ACTIVE: begin
        sReady = selOneHot & {PORTS{loadEn}};
        if (selValid && loadEn) begin
          mData_d  = selData;
          mKeep_d  = selKeep;
          mLast_d  = selLast;
          mUser_d  = selUser;
          mValid_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (selLast) begin
            frame_done = 1'b1;
            last_d     = grant_q;
            state_d    = IDLE;
          end else if (cnt_q == CNT_W'(MAX_BEATS - 1)) begin
            mLast_d         = 1'b1;
            mUser_d         = 1'b1;
            frame_truncated = 1'b1;
            state_d         = DROP;
          end
        end
      end

      DROP: begin
        sReady = selOneHot;
        if (selValid) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (selLast) begin
            frame_done = 1'b1;
            last_d     = grant_q;
            state_d    = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= IDX_W'(PORTS - 1);
      cnt_q    <= '0;
      mData_q  <= '0;
      mKeep_q  <= '0;
      mValid_q <= 1'b0;
      mLast_q  <= 1'b0;
      mUser_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      mData_q  <= mData_d;
      mKeep_q  <= mKeep_d;
      mValid_q <= mValid_d;
      mLast_q  <= mLast_d;
      mUser_q  <= mUser_d;
    end
  end

  assign axis.s_axis_tready = sReady;
  assign axis.m_axis_tdata  = mData_q;
  assign axis.m_axis_tkeep  = mKeep_q;
  assign axis.m_axis_tvalid = mValid_q;
  assign axis.m_axis_tlast  = mLast_q;
  assign axis.m_axis_tuser  = mUser_q;
  assign grant_valid        = (state_q != IDLE);
  assign grant_index        = grant_q;
endmodule

// File: tb/tb_eth_tx_axis_arbiter.sv
// Bench for eth_tx_axis_arbiter: per-port beat queues drive the requesters while
// a monitor pops an expected-beat queue whenever the output handshakes.
module tb_eth_tx_axis_arbiter;
  localparam int PORTS = 2;
  localparam int DW    = 64;
  localparam int KW    = 8;
  localparam int MAXB  = 4;
  localparam int IW    = 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
    int            gap;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          grantValid;
  logic [IW-1:0] grantIndex;
  logic          frameDone;
  logic          frameTrunc;

  beat_t txQ[PORTS][$];
  beat_t expQ[$];
  bit    rdyPat[$];
  int    checks   = 0;
  int    failures = 0;
  int    doneCnt  = 0;
  int    truncCnt = 0;
  int    sAcc     = 0;
  int    truncAt  = 0;
  int    doneAt   = 0;
  bit    scoreOff = 1'b0;
  bit    flushReq = 1'b0;

  always #5 clock = ~clock;

  eth_tx_axis_arbiter_if #(.PORTS(PORTS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) axis ();

  eth_tx_axis_arbiter #(
    .PORTS(PORTS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_BEATS(MAXB)
  ) dut (
    .logic_clk      (clock),
    .logic_rst      (reset),
    .axis           (axis),
    .grant_valid    (grantValid),
    .grant_index    (grantIndex),
    .frame_done     (frameDone),
    .frame_truncated(frameTrunc)
  );

  // One comparison: bump the counters and report a mismatch on a single line.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s timeout waiting for DUT", name);
  endtask

  // Queue one frame on a port; expected output beats follow the truncation rule.
  task automatic applyStimulus(input int port, input int nBeats, input bit userLast,
                               input int startGap, input int midGap, input int tag,
                               input bit pushExp);
    beat_t b;
    for (int i = 1; i <= nBeats; i++) begin
      b.data = {8'(port), 24'(tag), 32'(i)};
      b.keep = (i == nBeats) ? 8'h3F : 8'hFF;
      b.last = (i == nBeats);
      b.user = userLast && (i == nBeats);
      b.gap  = (i == 1) ? startGap : midGap;
      txQ[port].push_back(b);
      if (pushExp && i <= MAXB) begin
        if (i == MAXB && nBeats > MAXB) begin
          b.last = 1'b1;
          b.user = 1'b1;
        end
        expQ.push_back(b);
      end
    end
  endtask

  task automatic waitGrant(input string name);
    int n = 0;
    while (!grantValid && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) timeoutFail(name);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((txQ[0].size() + txQ[1].size() != 0 || expQ.size() != 0 || grantValid ||
            axis.m_axis_tvalid) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) timeoutFail(name);
    repeat (2) @(negedge clock);
  endtask

  // Requester and MAC-ready driver: updates once per cycle just after the rising edge.
  initial begin : driver
    logic [PORTS-1:0] acc;
    beat_t            b;
    axis.s_axis_tdata  = '0;
    axis.s_axis_tkeep  = '0;
    axis.s_axis_tvalid = '0;
    axis.s_axis_tlast  = '0;
    axis.s_axis_tuser  = '0;
    axis.m_axis_tready = 1'b1;
    forever begin
      @(negedge clock);
      acc = axis.s_axis_tvalid & axis.s_axis_tready;
      @(posedge clock);
      #1;
      for (int p = 0; p < PORTS; p++) begin
        if (flushReq) txQ[p].delete();
        else if (acc[p] && txQ[p].size() > 0) void'(txQ[p].pop_front());
        if (txQ[p].size() > 0 && txQ[p][0].gap > 0) begin
          b = txQ[p][0];
          b.gap--;
          txQ[p][0] = b;
          axis.s_axis_tvalid[p] = 1'b0;
        end else if (txQ[p].size() > 0) begin
          b = txQ[p][0];
          axis.s_axis_tvalid[p]            = 1'b1;
          axis.s_axis_tdata[p*DW +: DW]    = b.data;
          axis.s_axis_tkeep[p*KW +: KW]    = b.keep;
          axis.s_axis_tlast[p]             = b.last;
          axis.s_axis_tuser[p]             = b.user;
        end else begin
          axis.s_axis_tvalid[p] = 1'b0;
        end
      end
      if (rdyPat.size() > 0) axis.m_axis_tready = rdyPat.pop_front();
      else axis.m_axis_tready = 1'b1;
    end
  end

  // Output monitor: scoreboard pops, stall stability and pulse bookkeeping.
  initial begin : monitor
    bit            stallPrev = 1'b0;
    logic [DW-1:0] heldData;
    logic [KW-1:0] heldKeep;
    logic          heldLast, heldUser;
    beat_t         e;
    forever begin
      @(negedge clock);
      if (reset) begin
        sAcc      = 0;
        stallPrev = 1'b0;
      end else begin
        if (stallPrev) begin
          checkOutput("stall_data", 64'(axis.m_axis_tdata), 64'(heldData));
          checkOutput("stall_ctl",
                      64'({axis.m_axis_tvalid, axis.m_axis_tkeep, axis.m_axis_tlast, axis.m_axis_tuser}),
                      64'({1'b1, heldKeep, heldLast, heldUser}));
        end
        if (axis.m_axis_tvalid && axis.m_axis_tready && !scoreOff) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_beat actual=%0h expected=none", axis.m_axis_tdata);
          end else begin
            e = expQ.pop_front();
            checkOutput("out_data", 64'(axis.m_axis_tdata), 64'(e.data));
            checkOutput("out_keep_last_user",
                        64'({axis.m_axis_tkeep, axis.m_axis_tlast, axis.m_axis_tuser}),
                        64'({e.keep, e.last, e.user}));
          end
        end
        stallPrev = axis.m_axis_tvalid && !axis.m_axis_tready;
        heldData  = axis.m_axis_tdata;
        heldKeep  = axis.m_axis_tkeep;
        heldLast  = axis.m_axis_tlast;
        heldUser  = axis.m_axis_tuser;
        if (|(axis.s_axis_tvalid & axis.s_axis_tready)) sAcc++;
        if (frameTrunc) begin
          truncCnt++;
          truncAt = sAcc;
        end
        if (frameDone) begin
          doneCnt++;
          doneAt = sAcc;
          sAcc   = 0;
        end
      end
    end
  end

  initial begin : mainSeq
    int  d0, t0, n;
    bit  held;

    #2 reset = 1'b1;
    #1;
    checkOutput("rst_m_valid", 64'(axis.m_axis_tvalid), 64'(0));
    checkOutput("rst_m_data", 64'(axis.m_axis_tdata), 64'(0));
    checkOutput("rst_m_ctl", 64'({axis.m_axis_tkeep, axis.m_axis_tlast, axis.m_axis_tuser}), 64'(0));
    checkOutput("rst_s_ready", 64'(axis.s_axis_tready), 64'(0));
    checkOutput("rst_grant", 64'({grantValid, grantIndex}), 64'(0));
    checkOutput("rst_pulses", 64'({frameDone, frameTrunc}), 64'(0));
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    @(negedge clock);

    $display("[TB] single port 3-beat frame");
    d0 = doneCnt;
    applyStimulus(0, 3, 1'b0, 0, 0, 1, 1'b1);
    waitGrant("single_grant");
    checkOutput("single_grant_index", 64'(grantIndex), 64'(0));
    checkOutput("single_s_ready", 64'(axis.s_axis_tready), 64'(1));
    @(negedge clock);
    checkOutput("single_latency_valid", 64'(axis.m_axis_tvalid), 64'(1));
    checkOutput("single_latency_data", 64'(axis.m_axis_tdata), {8'd0, 24'd1, 32'd1});
    waitIdle("single_idle");
    checkOutput("single_done_count", 64'(doneCnt - d0), 64'(1));
    checkOutput("single_done_len", 64'(doneAt), 64'(3));

    $display("[TB] fairness 100 frames");
    d0 = doneCnt;
    for (int f = 0; f < 50; f++) begin
      applyStimulus(1, 2, 1'b0, 0, 0, 100 + f, 1'b1);
      applyStimulus(0, 2, 1'b0, 0, 0, 100 + f, 1'b1);
    end
    waitIdle("fair_idle");
    checkOutput("fair_done_count", 64'(doneCnt - d0), 64'(100));

    $display("[TB] backpressure 4-beat frame");
    d0 = doneCnt;
    t0 = truncCnt;
    applyStimulus(0, 4, 1'b0, 0, 0, 400, 1'b1);
    waitGrant("bp_grant");
    rdyPat.push_back(1'b1);
    rdyPat.push_back(1'b0);
    rdyPat.push_back(1'b0);
    rdyPat.push_back(1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (grantValid)
        checkOutput("bp_s_ready", 64'(axis.s_axis_tready),
                    64'({1'b0, !axis.m_axis_tvalid || axis.m_axis_tready}));
    end
    waitIdle("bp_idle");
    checkOutput("bp_done_count", 64'(doneCnt - d0), 64'(1));
    checkOutput("bp_no_trunc_at_limit", 64'(truncCnt - t0), 64'(0));

    $display("[TB] truncation 7-beat frame");
    d0 = doneCnt;
    t0 = truncCnt;
    applyStimulus(1, 7, 1'b0, 0, 0, 500, 1'b1);
    waitIdle("trunc_idle");
    checkOutput("trunc_count", 64'(truncCnt - t0), 64'(1));
    checkOutput("trunc_at_beat", 64'(truncAt), 64'(4));
    checkOutput("trunc_done_count", 64'(doneCnt - d0), 64'(1));
    checkOutput("trunc_done_beat", 64'(doneAt), 64'(7));

    $display("[TB] gaps with tuser on last beat");
    d0 = doneCnt;
    applyStimulus(0, 3, 1'b1, 0, 2, 600, 1'b1);
    applyStimulus(1, 1, 1'b0, 3, 0, 601, 1'b1);
    @(negedge clock);
    waitGrant("gap_grant");
    held = 1'b1;
    n    = 0;
    while (doneCnt == d0 && n < 100) begin
      if (!grantValid || grantIndex != 1'b0) held = 1'b0;
      @(negedge clock);
      n++;
    end
    if (n >= 100) timeoutFail("gap_frame");
    checkOutput("gap_grant_held", 64'(held), 64'(1));
    waitIdle("gap_idle");
    checkOutput("gap_done_count", 64'(doneCnt - d0), 64'(2));
    checkOutput("gap_single_beat_len", 64'(doneAt), 64'(1));

    $display("[TB] reset mid-frame");
    applyStimulus(0, 1, 1'b0, 0, 0, 700, 1'b1);
    waitIdle("pre_rst_idle");
    scoreOff = 1'b1;
    applyStimulus(0, 4, 1'b0, 0, 0, 701, 1'b0);
    n = 0;
    while (sAcc < 1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) timeoutFail("rst_wait_beat");
    @(posedge clock);
    #3 reset = 1'b1;
    flushReq = 1'b1;
    #1;
    checkOutput("midrst_m_valid", 64'(axis.m_axis_tvalid), 64'(0));
    checkOutput("midrst_s_ready", 64'(axis.s_axis_tready), 64'(0));
    checkOutput("midrst_grant_valid", 64'(grantValid), 64'(0));
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    flushReq = 1'b0;
    @(negedge clock);
    scoreOff = 1'b0;
    d0 = doneCnt;
    applyStimulus(0, 1, 1'b0, 0, 0, 800, 1'b1);
    applyStimulus(1, 1, 1'b0, 0, 0, 801, 1'b1);
    waitGrant("post_rst_grant");
    checkOutput("post_rst_first_winner", 64'(grantIndex), 64'(0));
    waitIdle("post_rst_idle");
    checkOutput("post_rst_done_count", 64'(doneCnt - d0), 64'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eth_tx_axis_arbiter.md
Name: eth_tx_axis_arbiter

Overview:
- Frame-granular round-robin arbiter that shares the 10G MAC FIFO tx_axis input among PORTS AXI-stream requesters, e.g. a CPU path and a hardware packet generator.
- Runs in the logic_clk domain, directly upstream of the MAC TX frame FIFO.
- Enforces a per-frame beat limit. An oversize frame is truncated and marked bad, so the MAC frame FIFO drops it.

Parameters:
PORTS, 2, number of requesters (2..8)
DATA_WIDTH, 64, tdata width
KEEP_WIDTH, 8, tkeep width (DATA_WIDTH/8)
MAX_BEATS, 1200, maximum beats per frame before truncation (9600 B at 64 bit)

Ports:
logic_clk  input  1  clock
logic_rst  input  1  asynchronous active-high reset
s_axis_tdata  input  PORTS*DATA_WIDTH  requester data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tkeep  input  PORTS*KEEP_WIDTH  requester byte enables
s_axis_tvalid  input  PORTS  requester valid
s_axis_tready  output  PORTS  requester ready
s_axis_tlast  input  PORTS  requester end of frame
s_axis_tuser  input  PORTS  requester bad-frame flag
m_axis_tdata  output  DATA_WIDTH  to MAC tx_axis_tdata
m_axis_tkeep  output  KEEP_WIDTH  to MAC tx_axis_tkeep
m_axis_tvalid  output  1  to MAC tx_axis_tvalid
m_axis_tready  input  1  from MAC tx_axis_tready
m_axis_tlast  output  1  to MAC tx_axis_tlast
m_axis_tuser  output  1  to MAC tx_axis_tuser
grant_valid  output  1  a port currently owns the output
grant_index  output  $clog2(PORTS) (min 1)  owning port
frame_done  output  1  one-cycle pulse when a frame's last beat is accepted from the requester
frame_truncated  output  1  one-cycle pulse when an oversize frame is cut

Behaviour:
- Single clock logic_clk. logic_rst is asynchronous and active-high.
- Reset values:
  - all m_axis_* outputs 0
  - s_axis_tready 0, grant_valid 0, grant_index 0
  - frame_done 0, frame_truncated 0
  - internal last_grant = PORTS-1, so port 0 wins first
  - beat counter 0, state IDLE
- Output stage is a single register. A beat accepted on the s side in cycle N is presented on m in cycle N+1.
- The output register may load when (!m_axis_tvalid || m_axis_tready). m_axis_tvalid clears when m_axis_tready is high and no new beat is loaded.
- m_axis_* holds stable while m_axis_tvalid && !m_axis_tready (AXI-stream rule).
- State IDLE:
  - s_axis_tready = 0.
  - If any s_axis_tvalid is set, grant the first set port searching from last_grant+1 upward, modulo PORTS.
  - Go to ACTIVE next cycle with grant_valid=1 and the beat counter cleared.
  - This costs one arbitration bubble per frame.
- State ACTIVE:
  - s_axis_tready[g] = (!m_axis_tvalid || m_axis_tready). All other ready bits are 0.
  - Each accepted beat is copied to m with tdata, tkeep, tlast and tuser passed through, and the beat counter increments.
  - Accepted beat with tlast=1: pulse frame_done, set last_grant=g, go to IDLE, drop grant_valid next cycle.
  - Accepted beat number MAX_BEATS with tlast=0: force m_axis_tlast=1 and m_axis_tuser=1, pulse frame_truncated, go to DROP.
- State DROP:
  - s_axis_tready[g] = 1. Beats are discarded and m is not loaded.
  - On an accepted beat with tlast=1: pulse frame_done, set last_grant=g, go to IDLE.
- A requester deasserting tvalid mid-frame keeps its grant; the arbiter never preempts mid-frame.
- Requests are sampled only in IDLE. A requester raising tvalid during another's frame waits.
- The beat counter is $clog2(MAX_BEATS+1) bits wide and saturates; it does not wrap.
- Reset mid-frame aborts immediately and m_axis_tvalid drops. The MAC frame FIFO is also reset by the same domain reset, so no partial frame persists.
- Single-beat frames (tlast on beat 1) are legal: ACTIVE for one accept, then IDLE.

Test Plan:
- Single port: port 0 sends a 3-beat frame with m_axis_tready=1 -> beats appear on m one cycle after acceptance, tlast on the 3rd, frame_done pulses once, grant_index=0.
- Fairness: ports 0 and 1 both continuously send 2-beat frames -> output order is frames from 0,1,0,1. One IDLE bubble between frames. Neither port starves over 100 frames.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat frame -> m_axis_* is stable while stalled, no beat lost or duplicated, s_axis_tready[0] follows (!m_axis_tvalid || m_axis_tready).
- Truncation: MAX_BEATS=4, port 1 sends a 7-beat frame -> m shows 4 beats with the 4th carrying tlast=1 and tuser=1. frame_truncated pulses at the 4th accept, beats 5-7 are accepted and discarded, frame_done pulses at beat 7.
- Pass-through error and gaps: port 0 sends tuser=1 on its last beat with tvalid gaps mid-frame -> grant is held across the gaps and m_axis_tuser=1 on the last output beat.
- Reset mid-frame: assert logic_rst during beat 2 -> m_axis_tvalid, s_axis_tready and grant_valid go 0 immediately. After release, port 0 wins first.
